// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised SPI master with runtime CPOL/CPHA, a programmable
// SCLK divider, NUM_CS active-low chip selects and full-duplex receive.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; config and dataIn latched on accept
// SETUP | chip select asserted, one SCLK half-period before first edge
// XFER  | 2*DATA_WIDTH SCLK edges, one per half-period
// HOLD  | SCLK parked at cpol for one half-period, select still low
// DONE  | single cycle: done pulse, dataOut updated, select released
module spi_master_multi #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_CS     = 4,
    parameter  int DIV_W      = 8,
    localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [CS_W-1:0]       csSel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_W-1:0]      clkDiv,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_CS-1:0]     cs_n
);

    localparam int EW = $clog2(2*DATA_WIDTH+1);
    localparam logic [EW-1:0] NUM_EDGES = EW'(2*DATA_WIDTH);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_WIDTH-1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} stateT;

    stateT                 state;
    stateT                 nextState;
    logic                  cpolL;
    logic                  cphaL;
    logic [DIV_W-1:0]      divL;
    logic [CS_W-1:0]       csL;
    logic [DIV_W-1:0]      divCnt;
    logic [EW-1:0]         edgeCnt;
    logic [DATA_WIDTH-1:0] txShift;
    logic [DATA_WIDTH-1:0] rxShift;
    logic                  csValid;
    logic                  accept;
    logic                  tick;
    logic                  edgeNow;
    logic                  leading;
    logic                  sampleNow;
    logic                  shiftNow;

    // Request qualification, half-period tick and per-edge sample/shift decisions.
    always_comb begin
        csValid   = (32'(csSel) < NUM_CS);
        accept    = (state == IDLE) && start && csValid;
        tick      = (divCnt == divL);
        edgeNow   = tick && ((state == SETUP) || ((state == XFER) && (edgeCnt != NUM_EDGES)));
        leading   = ~edgeCnt[0];
        sampleNow = leading ? ~cphaL : cphaL;
        shiftNow  = leading ? cphaL : (~cphaL && (edgeCnt != LAST_EDGE));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = SETUP;
            SETUP:   if (tick) nextState = XFER;
            XFER:    if (tick && (edgeCnt == NUM_EDGES)) nextState = HOLD;
            HOLD:    if (tick) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State-decoded outputs: busy, done and the one-hot active-low select.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if ((state == SETUP || state == XFER || state == HOLD) && (csL == CS_W'(i)))
                cs_n[i] = 1'b0;
        end
    end

    // Datapath: config latch, divider, SCLK generation, shift registers, err pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpolL   <= 1'b0;
            cphaL   <= 1'b0;
            divL    <= '0;
            csL     <= '0;
            divCnt  <= '0;
            edgeCnt <= '0;
            txShift <= '0;
            rxShift <= '0;
            dataOut <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= (state == IDLE) && start && !csValid;
            if (accept) begin
                cpolL   <= cpol;
                cphaL   <= cpha;
                divL    <= clkDiv;
                csL     <= csSel;
                divCnt  <= '0;
                edgeCnt <= '0;
                rxShift <= '0;
                sclk    <= cpol;
                // With cpha=0 the MSB must be on the wire before the first edge,
                // so it is presented now and the register keeps the remaining bits.
                if (cpha) begin
                    txShift <= dataIn;
                end else begin
                    txShift <= {dataIn[DATA_WIDTH-2:0], 1'b0};
                    mosi    <= dataIn[DATA_WIDTH-1];
                end
            end else if (state == SETUP || state == XFER || state == HOLD) begin
                divCnt <= tick ? '0 : divCnt + 1'b1;
                if (edgeNow) begin
                    sclk    <= ~sclk;
                    edgeCnt <= edgeCnt + 1'b1;
                    if (sampleNow) rxShift <= {rxShift[DATA_WIDTH-2:0], miso};
                    if (shiftNow) begin
                        mosi    <= txShift[DATA_WIDTH-1];
                        txShift <= {txShift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                if (state == HOLD) begin
                    sclk <= cpolL;
                    if (tick) dataOut <= rxShift;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi. NUM_CS=5 so that an out-of-range select
// (5 or 7) is representable on the 3-bit csSel port.
module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dataIn;
    logic [2:0] csSel;
    logic       cpol;
    logic       cpha;
    logic [7:0] clkDiv;
    logic       busy, done, err, sclk, mosi, miso;
    logic [7:0] dataOut;
    logic [4:0] cs_n;

    int total = 0;
    int bad   = 0;

    logic       slaveEn   = 1'b0;
    logic       slaveLoad = 1'b0;
    logic [7:0] slaveTx   = 8'h00;
    logic [7:0] slaveSh   = 8'h00;
    logic       slaveMiso = 1'b0;
    logic [7:0] slaveRx   = 8'h00;
    int         twoLow    = 0;

    spi_master_multi #(.DATA_WIDTH(8), .NUM_CS(5), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dataIn(dataIn), .csSel(csSel),
        .cpol(cpol), .cpha(cpha), .clkDiv(clkDiv), .busy(busy), .done(done),
        .err(err), .dataOut(dataOut), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    assign miso = slaveEn ? slaveMiso : mosi;

    // Mode-3 slave: drives its next bit on falling SCLK, captures MOSI on rising SCLK.
    always @(negedge sclk or posedge slaveLoad) begin
        if (slaveLoad) slaveSh <= slaveTx;
        else begin
            slaveMiso <= slaveSh[7];
            slaveSh   <= {slaveSh[6:0], 1'b0};
        end
    end

    always @(posedge sclk) slaveRx <= {slaveRx[6:0], mosi};

    always @(negedge clk) if ($countones(~cs_n) > 1) twoLow++;

    // Launches one transfer and measures it cycle by cycle (cycle 1 = first cycle after accept).
    task automatic doTransfer(input logic [7:0] d, input logic [2:0] cs, input logic cp,
                              input logic ch, input logic [7:0] div, input int injAt,
                              input logic [7:0] injD, input int tail,
                              output int doneCyc, output int rises, output int toggles,
                              output int minGap, output int maxGap, output logic [7:0] rx,
                              output int dones, output int csWrong, output int tailBusy,
                              output logic sclkFirst);
        int n, lastT, post, gap;
        logic prevS, seenDone;
        logic [4:0] expCs;
        start = 1'b1; dataIn = d; csSel = cs; cpol = cp; cpha = ch; clkDiv = div;
        @(posedge clk); #1;
        start = 1'b0; dataIn = ~d; cpol = ~cp; cpha = ~ch; clkDiv = 8'h05; csSel = 3'd0;
        doneCyc = -1; rises = 0; toggles = 0; minGap = 1000000; maxGap = 0; rx = 8'h00;
        dones = 0; csWrong = 0; tailBusy = 0; sclkFirst = 1'b0;
        n = 0; lastT = 1; post = 0; prevS = 1'b0; seenDone = 1'b0;
        while (n < 2000 && !(seenDone && post >= tail)) begin
            @(negedge clk);
            n++;
            if (seenDone) begin
                post++;
                if (busy) tailBusy++;
            end
            if (n == 1) begin
                prevS = sclk; sclkFirst = sclk;
            end else if (sclk !== prevS) begin
                toggles++;
                if (sclk === 1'b1) rises++;
                gap = n - lastT;
                if (gap < minGap) minGap = gap;
                if (gap > maxGap) maxGap = gap;
                lastT = n; prevS = sclk;
            end
            expCs = (busy && !done) ? ~(5'b00001 << cs) : 5'b11111;
            if (cs_n !== expCs) csWrong++;
            if (done === 1'b1) begin
                dones++;
                if (!seenDone) begin
                    seenDone = 1'b1; doneCyc = n; rx = dataOut;
                end
            end
            if (n == injAt) begin
                start = 1'b1; dataIn = injD;
            end else start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (dataOut !== 8'h00) begin bad++; $display("FAIL reset_dataOut: got %h want 00", dataOut); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        total++; if (cs_n !== 5'b11111) begin bad++; $display("FAIL reset_cs_n: got %b want 11111", cs_n); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        int dc, ri, tg, mn, mx, dn, cw, tb;
        logic [7:0] rx;
        logic sf;
        doTransfer(8'hA5, 3'd0, 1'b0, 1'b0, 8'd0, -1, 8'h00, 2, dc, ri, tg, mn, mx, rx, dn, cw, tb, sf);
        total++; if (dc != 19) begin bad++; $display("FAIL mode0_latency: got %0d want 19", dc); end
        total++; if (rx !== 8'hA5) begin bad++; $display("FAIL mode0_data: got %h want a5", rx); end
        total++; if (ri != 8) begin bad++; $display("FAIL mode0_rises: got %0d want 8", ri); end
        total++; if (cw != 0) begin bad++; $display("FAIL mode0_cs: got %0d bad cycles want 0", cw); end
        total++; if (tb != 0) begin bad++; $display("FAIL mode0_busy_after: got %0d want 0", tb); end
    endtask

    task automatic test_mode3();
        int dc, ri, tg, mn, mx, dn, cw, tb;
        logic [7:0] rx;
        logic sf;
        slaveEn = 1'b1; slaveTx = 8'h3C;
        slaveLoad = 1'b1; #1; slaveLoad = 1'b0;
        doTransfer(8'hC3, 3'd0, 1'b1, 1'b1, 8'd3, -1, 8'h00, 2, dc, ri, tg, mn, mx, rx, dn, cw, tb, sf);
        total++; if (dc != 73) begin bad++; $display("FAIL mode3_latency: got %0d want 73", dc); end
        total++; if (rx !== 8'h3C) begin bad++; $display("FAIL mode3_rx: got %h want 3c", rx); end
        total++; if (slaveRx !== 8'hC3) begin bad++; $display("FAIL mode3_slave_rx: got %h want c3", slaveRx); end
        total++; if (sf !== 1'b1) begin bad++; $display("FAIL mode3_idle_start: got %b want 1", sf); end
        total++; if (sclk !== 1'b1) begin bad++; $display("FAIL mode3_idle_end: got %b want 1", sclk); end
        total++; if (tg != 16) begin bad++; $display("FAIL mode3_edges: got %0d want 16", tg); end
        total++; if (mn != 4 || mx != 4) begin bad++; $display("FAIL mode3_half_period: got %0d..%0d want 4", mn, mx); end
        total++; if (cw != 0) begin bad++; $display("FAIL mode3_cs: got %0d bad cycles want 0", cw); end
        slaveEn = 1'b0;
    endtask

    task automatic test_ignore_busy();
        int dc, ri, tg, mn, mx, dn, cw, tb;
        logic [7:0] rx;
        logic sf;
        doTransfer(8'h5A, 3'd1, 1'b0, 1'b0, 8'd0, 5, 8'hFF, 5, dc, ri, tg, mn, mx, rx, dn, cw, tb, sf);
        total++; if (dn != 1) begin bad++; $display("FAIL busy_ignore_dones: got %0d want 1", dn); end
        total++; if (rx !== 8'h5A) begin bad++; $display("FAIL busy_ignore_data: got %h want 5a", rx); end
        total++; if (dc != 19) begin bad++; $display("FAIL busy_ignore_latency: got %0d want 19", dc); end
        total++; if (tb != 0) begin bad++; $display("FAIL busy_ignore_restart: got %0d busy cycles want 0", tb); end
    endtask

    task automatic test_bad_cs();
        logic idleS;
        logic [2:0] badSel [2] = '{3'd5, 3'd7};
        for (int k = 0; k < 2; k++) begin
            idleS = sclk;
            start = 1'b1; csSel = badSel[k]; dataIn = 8'h11;
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            total++; if (err !== 1'b1) begin bad++; $display("FAIL badcs_err: got %b want 1 (sel %0d)", err, badSel[k]); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL badcs_busy: got %b want 0", busy); end
            total++; if (cs_n !== 5'b11111) begin bad++; $display("FAIL badcs_cs_n: got %b want 11111", cs_n); end
            total++; if (sclk !== idleS) begin bad++; $display("FAIL badcs_sclk: got %b want %b", sclk, idleS); end
            @(negedge clk);
            total++; if (err !== 1'b0) begin bad++; $display("FAIL badcs_err_width: got %b want 0", err); end
        end
    endtask

    task automatic test_reset_mid();
        int dc, ri, tg, mn, mx, dn, cw, tb;
        logic [7:0] rx;
        logic sf;
        start = 1'b1; dataIn = 8'h3C; csSel = 3'd1; cpol = 1'b0; cpha = 1'b1; clkDiv = 8'd1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        rst = 1'b1; #1;
        total++; if (cs_n !== 5'b11111) begin bad++; $display("FAIL rstmid_cs_n: got %b want 11111", cs_n); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rstmid_sclk: got %b want 0", sclk); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (dataOut !== 8'h00) begin bad++; $display("FAIL rstmid_dataOut: got %h want 00", dataOut); end
        @(posedge clk); @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
        rst = 1'b0;
        @(negedge clk);
        doTransfer(8'h96, 3'd4, 1'b0, 1'b1, 8'd1, -1, 8'h00, 1, dc, ri, tg, mn, mx, rx, dn, cw, tb, sf);
        total++; if (dc != 37) begin bad++; $display("FAIL rstmid_after_latency: got %0d want 37", dc); end
        total++; if (rx !== 8'h96) begin bad++; $display("FAIL rstmid_after_data: got %h want 96", rx); end
        total++; if (cw != 0) begin bad++; $display("FAIL rstmid_after_cs: got %0d bad cycles want 0", cw); end
    endtask

    task automatic test_back_to_back();
        int dc, ri, tg, mn, mx, dn, cw, tb;
        int dc2, cw2;
        logic [7:0] rx, rx2;
        logic sf;
        twoLow = 0;
        doTransfer(8'h81, 3'd2, 1'b0, 1'b0, 8'd0, -1, 8'h00, 1, dc, ri, tg, mn, mx, rx, dn, cw, tb, sf);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
        doTransfer(8'h7E, 3'd3, 1'b1, 1'b0, 8'd0, -1, 8'h00, 3, dc2, ri, tg, mn, mx, rx2, dn, cw2, tb, sf);
        total++; if (rx !== 8'h81) begin bad++; $display("FAIL b2b_first_data: got %h want 81", rx); end
        total++; if (rx2 !== 8'h7E) begin bad++; $display("FAIL b2b_second_data: got %h want 7e", rx2); end
        total++; if (dc != 19 || dc2 != 19) begin bad++; $display("FAIL b2b_latency: got %0d,%0d want 19,19", dc, dc2); end
        total++; if (cw != 0 || cw2 != 0) begin bad++; $display("FAIL b2b_cs: got %0d,%0d bad cycles want 0", cw, cw2); end
        total++; if (twoLow != 0) begin bad++; $display("FAIL b2b_two_low: got %0d cycles want 0", twoLow); end
        total++; if (sclk !== 1'b1) begin bad++; $display("FAIL b2b_mode2_idle: got %b want 1", sclk); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dataIn = 8'h00; csSel = 3'd0;
        cpol = 1'b0; cpha = 1'b0; clkDiv = 8'd0;
        test_reset();
        test_mode0();
        test_mode3();
        test_ignore_busy();
        test_bad_cs();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
